jpeg_bitstream_aligner: RTL and testbench

- Upstream of huffman_decoder: turns the entropy-coded byte stream into a left-aligned 16-bit window that drives huffman_decoder's `code` input.
- Removes JPEG byte stuffing (FF 00 -> FF) and skips fill bytes (FF FF).
- Detects markers and stops accepting input when one is found.
- Frees a variable number of bits each cycle on request from the decode control (Huffman code length plus additional-bit length).

---
 rtl/jpeg_bitstream_aligner.sv | 178 +++++++++++++++++
 tb/tb_jpeg_bitstream_aligner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_aligner.sv
// JPEG entropy-coded bitstream aligner.
// Strips byte stuffing (FF 00 -> FF), skips fill bytes (FF FF), stops at the
// first marker and presents the next 16 stream bits as a left-aligned window
// for the Huffman decoder. The decode control frees 1..16 bits per cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STREAM | normal entropy data; bytes other than 0xFF load directly
// ST_SAW_FF | previous byte was 0xFF; next byte decides stuff/fill/marker
// ST_MARKER | marker seen; input stalled, padding bits read as 1

module jpeg_bitstream_aligner #(
    parameter int BUF_BITS = 32,
    parameter int WIN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIN_BITS-1:0] window,
    output logic                window_valid,
    output logic [5:0]          bit_count,
    input  logic                consume_en,
    input  logic [4:0]          consume_len,
    output logic                marker_found,
    output logic [7:0]          marker_code,
    input  logic                marker_clear
);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_SAW_FF = 2'd1,
        ST_MARKER = 2'd2
    } state_t;

    localparam logic [5:0] WIN_CNT  = 6'(WIN_BITS);
    localparam logic [5:0] LOAD_MAX = 6'(BUF_BITS - 8);

    state_t              state_q, state_d;
    logic [BUF_BITS-1:0] buffer_q, buffer_d;
    logic [5:0]          count_q, count_d;
    logic                mfound_q, mfound_d;
    logic [7:0]          mcode_q, mcode_d;

    logic [4:0]          len_eff;
    logic [5:0]          len6;
    logic [BUF_BITS-1:0] ones;
    logic [BUF_BITS-1:0] shifted;
    logic [5:0]          count_shift;
    logic                accept;
    logic                load_en;
    logic [7:0]          load_byte;
    logic                enter_marker;
    logic [BUF_BITS-1:0] placed;

    // Outputs derived from registered state only, so in_ready never depends
    // on this cycle's consume request.
    always_comb begin
        in_ready     = (state_q != ST_MARKER) && (count_q <= LOAD_MAX);
        window       = buffer_q[BUF_BITS-1 -: WIN_BITS];
        bit_count    = count_q;
        marker_found = mfound_q;
        marker_code  = mcode_q;
        if (state_q == ST_MARKER)
            window_valid = (count_q != 6'd0);
        else
            window_valid = (count_q >= WIN_CNT);
    end

    // Consume stage: shift first, so a byte loaded in the same cycle lands
    // directly behind the bits that remain.
    always_comb begin
        ones        = '1;
        len_eff     = (consume_len > 5'd16) ? 5'd16 : consume_len;
        len6        = {1'b0, len_eff};
        shifted     = buffer_q;
        count_shift = count_q;
        if (consume_en && (len_eff != 5'd0)) begin
            if (state_q == ST_MARKER) begin
                // End-of-scan padding: refill with ones and never underflow.
                shifted     = (buffer_q << len_eff) | ~(ones << len_eff);
                count_shift = (count_q > len6) ? (count_q - len6) : 6'd0;
            end else if (count_q >= WIN_CNT) begin
                // Consuming a partially filled window is illegal and dropped.
                shifted     = buffer_q << len_eff;
                count_shift = count_q - len6;
            end
        end
    end

    // Next-state and byte-load decision.
    always_comb begin
        state_d      = state_q;
        mfound_d     = mfound_q;
        mcode_d      = mcode_q;
        load_en      = 1'b0;
        load_byte    = 8'h00;
        enter_marker = 1'b0;
        accept       = in_valid && in_ready;

        case (state_q)
            ST_STREAM: begin
                if (accept) begin
                    if (in_byte == 8'hFF) begin
                        state_d = ST_SAW_FF;
                    end else begin
                        load_en   = 1'b1;
                        load_byte = in_byte;
                    end
                end
            end
            ST_SAW_FF: begin
                if (accept) begin
                    if (in_byte == 8'h00) begin
                        load_en   = 1'b1;
                        load_byte = 8'hFF;
                        state_d   = ST_STREAM;
                    end else if (in_byte != 8'hFF) begin
                        mcode_d      = in_byte;
                        mfound_d     = 1'b1;
                        enter_marker = 1'b1;
                        state_d      = ST_MARKER;
                    end
                end
            end
            ST_MARKER: begin
                state_d = ST_MARKER;
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase

        if (marker_clear) begin
            state_d  = ST_STREAM;
            mfound_d = 1'b0;
            mcode_d  = 8'h00;
        end
    end

    // Buffer and count update; marker_clear wins over consume and load.
    always_comb begin
        placed   = {load_byte, {(BUF_BITS-8){1'b0}}} >> count_shift;
        buffer_d = shifted;
        count_d  = count_shift;
        if (load_en) begin
            buffer_d = shifted | placed;
            count_d  = count_shift + 6'd8;
        end
        if (enter_marker) begin
            // From here on the bits below the valid region read as 1.
            buffer_d = shifted | (ones >> count_shift);
        end
        if (marker_clear) begin
            buffer_d = '0;
            count_d  = 6'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_STREAM;
            buffer_q <= '0;
            count_q  <= 6'd0;
            mfound_q <= 1'b0;
            mcode_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            count_q  <= count_d;
            mfound_q <= mfound_d;
            mcode_q  <= mcode_d;
        end
    end

endmodule

// File: tb/tb_jpeg_bitstream_aligner.sv
// Directed testbench for jpeg_bitstream_aligner.
module tb_jpeg_bitstream_aligner;

    logic        clk;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] window;
    logic        window_valid;
    logic [5:0]  bit_count;
    logic        consume_en;
    logic [4:0]  consume_len;
    logic        marker_found;
    logic [7:0]  marker_code;
    logic        marker_clear;

    int checks = 0;
    int errors = 0;

    jpeg_bitstream_aligner #(.BUF_BITS(32), .WIN_BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .window       (window),
        .window_valid (window_valid),
        .bit_count    (bit_count),
        .consume_en   (consume_en),
        .consume_len  (consume_len),
        .marker_found (marker_found),
        .marker_code  (marker_code),
        .marker_clear (marker_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume(input logic [4:0] len);
        consume_en  = 1'b1;
        consume_len = len;
        tick();
        consume_en  = 1'b0;
        consume_len = 5'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bit_count); end
        checks++; if (window !== 16'h0000) begin errors++; $display("FAIL reset_window got %h want 0000", window); end
        checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b want 0", window_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        checks++; if (marker_found !== 1'b0 || marker_code !== 8'h00) begin errors++; $display("FAIL reset_marker got %b/%h want 0/00", marker_found, marker_code); end
    endtask

    task automatic test_basic_load();
        send(8'hA5);
        checks++; if (bit_count !== 6'd8 || window !== 16'hA500 || window_valid !== 1'b0) begin errors++; $display("FAIL load1 got %0d/%h/%b want 8/a500/0", bit_count, window, window_valid); end
        send(8'h3C);
        checks++; if (bit_count !== 6'd16) begin errors++; $display("FAIL load2_count got %0d want 16", bit_count); end
        checks++; if (window !== 16'hA53C || window_valid !== 1'b1) begin errors++; $display("FAIL load2_window got %h/%b want a53c/1", window, window_valid); end
        checks++; if (marker_found !== 1'b0) begin errors++; $display("FAIL load2_marker got %b want 0", marker_found); end
    endtask

    task automatic test_consume_with_load();
        consume_en  = 1'b1;
        consume_len = 5'd4;
        send(8'h7E);
        consume_en  = 1'b0;
        consume_len = 5'd0;
        checks++; if (bit_count !== 6'd20) begin errors++; $display("FAIL cons_load_count got %0d want 20", bit_count); end
        checks++; if (window !== 16'h53C7) begin errors++; $display("FAIL cons_load_window got %h want 53c7", window); end
    endtask

    task automatic test_stuffing();
        do_reset();
        send(8'hFF);
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL stuff_ff_held got %0d want 0", bit_count); end
        send(8'h00);
        checks++; if (bit_count !== 6'd8 || window !== 16'hFF00) begin errors++; $display("FAIL stuff_00 got %0d/%h want 8/ff00", bit_count, window); end
        send(8'h12);
        checks++; if (bit_count !== 6'd16 || window !== 16'hFF12) begin errors++; $display("FAIL stuff_12 got %0d/%h want 16/ff12", bit_count, window); end
        do_reset();
        send(8'hFF);
        send(8'hFF);
        send(8'h00);
        send(8'h12);
        checks++; if (bit_count !== 6'd16 || window !== 16'hFF12 || marker_found !== 1'b0) begin errors++; $display("FAIL fill_skip got %0d/%h/%b want 16/ff12/0", bit_count, window, marker_found); end
    endtask

    task automatic test_marker();
        do_reset();
        send(8'h34);
        send(8'hFF);
        send(8'hD9);
        checks++; if (marker_found !== 1'b1 || marker_code !== 8'hD9) begin errors++; $display("FAIL marker_det got %b/%h want 1/d9", marker_found, marker_code); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL marker_ready got %b want 0", in_ready); end
        checks++; if (window !== 16'h34FF || window_valid !== 1'b1 || bit_count !== 6'd8) begin errors++; $display("FAIL marker_window got %h/%b/%0d want 34ff/1/8", window, window_valid, bit_count); end
        send(8'h55);
        checks++; if (bit_count !== 6'd8) begin errors++; $display("FAIL marker_stall got %0d want 8", bit_count); end
        consume(5'd12);
        checks++; if (bit_count !== 6'd0 || window_valid !== 1'b0) begin errors++; $display("FAIL marker_sat got %0d/%b want 0/0", bit_count, window_valid); end
        checks++; if (window !== 16'hFFFF) begin errors++; $display("FAIL marker_pad got %h want ffff", window); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        checks++; if (bit_count !== 6'd24 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_24 got %0d/%b want 24/1", bit_count, in_ready); end
        send(8'h44);
        checks++; if (bit_count !== 6'd32 || in_ready !== 1'b0 || window !== 16'h1122) begin errors++; $display("FAIL bp_32 got %0d/%b/%h want 32/0/1122", bit_count, in_ready, window); end
        send(8'h55);
        checks++; if (bit_count !== 6'd32 || window !== 16'h1122) begin errors++; $display("FAIL bp_blocked got %0d/%h want 32/1122", bit_count, window); end
        consume(5'd8);
        checks++; if (bit_count !== 6'd24 || in_ready !== 1'b1 || window !== 16'h2233) begin errors++; $display("FAIL bp_free got %0d/%b/%h want 24/1/2233", bit_count, in_ready, window); end
        consume(5'd8);
        consume(5'd4);
        checks++; if (bit_count !== 6'd12 || window !== 16'h3440 || window_valid !== 1'b0) begin errors++; $display("FAIL bp_12 got %0d/%h/%b want 12/3440/0", bit_count, window, window_valid); end
        consume(5'd4);
        checks++; if (bit_count !== 6'd12 || window !== 16'h3440) begin errors++; $display("FAIL illegal_consume got %0d/%h want 12/3440", bit_count, window); end
    endtask

    task automatic test_clamp();
        do_reset();
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        consume(5'd31);
        checks++; if (bit_count !== 6'd16 || window !== 16'hCCDD) begin errors++; $display("FAIL clamp got %0d/%h want 16/ccdd", bit_count, window); end
        consume(5'd0);
        checks++; if (bit_count !== 6'd16 || window !== 16'hCCDD) begin errors++; $display("FAIL len0_noop got %0d/%h want 16/ccdd", bit_count, window); end
    endtask

    task automatic test_clear_and_async_reset();
        do_reset();
        send(8'h34);
        send(8'hFF);
        send(8'hD9);
        marker_clear = 1'b1;
        consume_en   = 1'b1;
        consume_len  = 5'd4;
        tick();
        marker_clear = 1'b0;
        consume_en   = 1'b0;
        consume_len  = 5'd0;
        checks++; if (bit_count !== 6'd0 || marker_found !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear got %0d/%b/%b want 0/0/1", bit_count, marker_found, in_ready); end
        checks++; if (marker_code !== 8'h00 || window !== 16'h0000) begin errors++; $display("FAIL clear_regs got %h/%h want 00/0000", marker_code, window); end
        send(8'h56);
        checks++; if (bit_count !== 6'd8 || window !== 16'h5600) begin errors++; $display("FAIL after_clear got %0d/%h want 8/5600", bit_count, window); end
        send(8'hA5);
        in_valid = 1'b1;
        in_byte  = 8'h3C;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bit_count !== 6'd0 || window !== 16'h0000 || window_valid !== 1'b0) begin errors++; $display("FAIL async_reset got %0d/%h/%b want 0/0000/0", bit_count, window, window_valid); end
        checks++; if (in_ready !== 1'b1 || marker_found !== 1'b0 || marker_code !== 8'h00) begin errors++; $display("FAIL async_reset_ctl got %b/%b/%h want 1/0/00", in_ready, marker_found, marker_code); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL post_reset got %0d want 0", bit_count); end
    endtask

    initial begin
        reset        = 1'b1;
        in_byte      = 8'h00;
        in_valid     = 1'b0;
        consume_en   = 1'b0;
        consume_len  = 5'd0;
        marker_clear = 1'b0;
        test_reset();
        test_basic_load();
        test_consume_with_load();
        test_stuffing();
        test_marker();
        test_backpressure();
        test_clamp();
        test_clear_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
